lfsr_stream_checker: RTL and testbench
======================================

Name: lfsr_stream_checker

Overview:
- Downstream consumer of the team's 16-bit Fibonacci LFSR generator.
- Receives the generator's output word stream and self-synchronises to the sequence.
- Checks every subsequent word against the locally predicted next value.
- Reports lock status and a saturating error count, for PRBS self-test of the datapath between generator and checker.

Parameters:
LOCK_CNT, 4, consecutive correct predictions needed in VERIFY before declaring lock (1..15)
UNLOCK_CNT, 3, consecutive mismatches in LOCKED that drop lock (1..15)
CNT_W, 16, width of error counter

Ports:
clk  input  1  clock, all state updates on rising edge
nReset  input  1  asynchronous active-low reset
in_valid  input  1  in_data holds a sample this cycle
in_data  input  16  LFSR word from generator
clear_err  input  1  synchronous clear of err_count and err_sat
locked  output  1  high while state is LOCKED
err_pulse  output  1  one-cycle pulse per counted mismatch
err_count  output  CNT_W  saturating mismatch count (LOCKED only)
err_sat  output  1  sticky, err_count has reached all-ones

Behaviour:
- Next-state function: nxt(x) = {x[14:0], x[15]^x[13]^x[12]^x[10]}.
  - Identical to the generator's update: shift left, feedback into bit 0.
- Reset (nReset low, async):
  - state=HUNT; expected, match_cnt and miss_cnt = 0.
  - Outputs: locked=0, err_pulse=0, err_count=0, err_sat=0.
  - Reset mid-operation discards lock immediately.
- Cycles with in_valid=0:
  - No state, expected, or counter change.
  - err_pulse=0.
- HUNT:
  - On valid with in_data != 0: expected <= nxt(in_data), match_cnt <= 0, go VERIFY.
  - in_data == 0 (LFSR lockup word) is never used as a seed; stay HUNT.
- VERIFY:
  - On valid, in_data == expected:
    - expected <= nxt(in_data); match_cnt++.
    - If match_cnt+1 == LOCK_CNT: go LOCKED, miss_cnt <= 0.
  - On valid, mismatch:
    - Re-seed from the current word: if in_data != 0, expected <= nxt(in_data), match_cnt <= 0, stay VERIFY.
    - Else go HUNT.
  - No errors are counted in HUNT or VERIFY.
- LOCKED:
  - expected always advances from the prediction: expected <= nxt(expected).
    - A corrupted word therefore counts as exactly one error and does not propagate.
  - Match: miss_cnt <= 0.
  - Mismatch:
    - err_pulse=1 next cycle.
    - err_count++ unless already all-ones.
    - err_sat <= 1 when err_count becomes all-ones.
    - miss_cnt++; if miss_cnt+1 == UNLOCK_CNT, go HUNT. The mismatch that unlocks is still counted.
- Registered outputs:
  - locked, err_pulse and err_count reflect a sample one cycle after the edge on which it is accepted.
  - Latency is 1 cycle.
- clear_err:
  - Zeroes err_count and err_sat next edge; does not affect state or lock.
  - If clear_err and a counted mismatch occur in the same cycle: err_count <= 1, err_pulse=1.
- Saturation: err_count holds at 2^CNT_W-1; err_pulse still fires per mismatch.

Test Plan:
- Reset, then valid stream 0xACE1, 0x59C3, 0xB387, … (correct sequence):
  - locked rises one cycle after the 5th sample (1 seed + LOCK_CNT=4 matches).
  - err_count stays 0.
- Locked, then one sample corrupted (0x0001 in place of expected word), then correct words resume:
  - Exactly one err_pulse; err_count=1; locked stays 1.
- Locked, then 3 consecutive wrong words:
  - err_count=3; locked falls one cycle after the 3rd.
  - A correct stream re-locks after 5 further samples.
- In HUNT, feed 0x0000 repeatedly:
  - Stays HUNT, locked=0, err_count=0.
  - Next 0x8000, 0x0001, 0x0002, 0x0004, 0x0008 → locked=1.
- CNT_W=2, locked, continuous mismatches with UNLOCK_CNT=15:
  - err_count reaches 3 and holds; err_sat=1.
  - clear_err → err_count=0 and err_sat=0 next cycle; locked unaffected.
- Assert nReset mid-stream while locked with err_count=2:
  - locked, err_count and err_pulse go 0 immediately (async, no clock edge).
  - After release, HUNT behaviour resumes.

Source files
------------

// File: rtl/lfsr_stream_checker.sv
// PRBS checker for the 16-bit Fibonacci LFSR generator: self-synchronises to the
// incoming word stream, then counts mismatches against the locally predicted sequence.
module lfsr_stream_checker #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic             err_sat
);

  // state  | meaning
  // HUNT   | waiting for a non-zero word to seed the predictor
  // VERIFY | seeded, counting consecutive correct predictions toward lock
  // LOCKED | tracking the sequence, counting mismatches as errors
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0]       LOCK_TC   = 4'(LOCK_CNT);
  localparam logic [3:0]       UNLOCK_TC = 4'(UNLOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  function automatic logic [15:0] nxt(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  state_t           state, state_nxt;
  logic [15:0]      expected, expected_nxt;
  logic [3:0]       match_cnt, match_nxt;
  logic [3:0]       miss_cnt, miss_nxt;
  logic             pulse_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] cnt_base;
  logic             sat_nxt;
  logic             count_err;
  logic             hit;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= HUNT;
      expected  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
      err_sat   <= 1'b0;
    end else begin
      state     <= state_nxt;
      expected  <= expected_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      err_pulse <= pulse_nxt;
      err_count <= count_nxt;
      err_sat   <= sat_nxt;
    end
  end

  assign locked = (state == LOCKED);

  always_comb begin
    state_nxt    = state;
    expected_nxt = expected;
    match_nxt    = match_cnt;
    miss_nxt     = miss_cnt;
    pulse_nxt    = 1'b0;
    count_err    = 1'b0;
    hit          = (in_data == expected);
    cnt_base     = clear_err ? '0 : err_count;
    count_nxt    = cnt_base;
    sat_nxt      = clear_err ? 1'b0 : err_sat;

    if (in_valid) begin
      unique case (state)
        HUNT: begin
          if (in_data != '0) begin
            expected_nxt = nxt(in_data);
            match_nxt    = '0;
            state_nxt    = VERIFY;
          end
        end
        VERIFY: begin
          if (hit) begin
            expected_nxt = nxt(in_data);
            match_nxt    = match_cnt + 4'd1;
            if (match_cnt + 4'd1 == LOCK_TC) begin
              state_nxt = LOCKED;
              miss_nxt  = '0;
            end
          end else if (in_data != '0) begin
            expected_nxt = nxt(in_data);
            match_nxt    = '0;
          end else begin
            state_nxt = HUNT;
          end
        end
        LOCKED: begin
          // Advance from the prediction so one corrupted word costs exactly one error.
          expected_nxt = nxt(expected);
          if (hit) begin
            miss_nxt = '0;
          end else begin
            count_err = 1'b1;
            miss_nxt  = miss_cnt + 4'd1;
            if (miss_cnt + 4'd1 == UNLOCK_TC) state_nxt = HUNT;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end

    if (count_err) begin
      pulse_nxt = 1'b1;
      if (cnt_base != '1) count_nxt = cnt_base + CNT_ONE;
      if (count_nxt == '1) sat_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed bench: default checker (a) plus a 2-bit counter / UNLOCK_CNT=15 checker (b)
// sharing one stimulus stream.
module tb_lfsr_stream_checker;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        clear_err = 1'b0;

  logic        locked_a, err_pulse_a, err_sat_a;
  logic [15:0] err_count_a;
  logic        locked_b, err_pulse_b, err_sat_b;
  logic [1:0]  err_count_b;

  int checks = 0;
  int errors = 0;
  logic [15:0] w;

  always #5 clk = ~clk;

  lfsr_stream_checker dut_a (
    .clk(clk), .nReset(nReset), .in_valid(in_valid), .in_data(in_data),
    .clear_err(clear_err), .locked(locked_a), .err_pulse(err_pulse_a),
    .err_count(err_count_a), .err_sat(err_sat_a)
  );

  lfsr_stream_checker #(.LOCK_CNT(4), .UNLOCK_CNT(15), .CNT_W(2)) dut_b (
    .clk(clk), .nReset(nReset), .in_valid(in_valid), .in_data(in_data),
    .clear_err(clear_err), .locked(locked_b), .err_pulse(err_pulse_b),
    .err_count(err_count_b), .err_sat(err_sat_b)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One sample accepted on the next rising edge; outputs are settled on return.
  task automatic feed(input logic [15:0] d, input logic clr = 1'b0);
    in_valid  = 1'b1;
    in_data   = d;
    clear_err = clr;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic idle(input logic clr = 1'b0);
    clear_err = clr;
    @(posedge clk);
    #1;
    clear_err = 1'b0;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nReset = 1'b1;
  endtask

  initial begin
    #2;
    chk("rst_locked", locked_a, 0);
    chk("rst_pulse", err_pulse_a, 0);
    chk("rst_count", err_count_a, 0);
    chk("rst_sat", err_sat_a, 0);
    do_reset();

    // Correct stream with an idle cycle in VERIFY; lock after seed + 4 matches.
    w = 16'hACE1;
    chk("seq_w1", lfsr_next(w), 16'h59C3);
    feed(w); w = lfsr_next(w);
    feed(w); w = lfsr_next(w);
    idle();
    chk("idle_verify_locked", locked_a, 0);
    feed(w); w = lfsr_next(w);
    feed(w); w = lfsr_next(w);
    chk("lock_after4", locked_a, 0);
    feed(w); w = lfsr_next(w);
    chk("lock_after5", locked_a, 1);
    chk("lock_count", err_count_a, 0);
    feed(w); w = lfsr_next(w);

    // Single corrupted word.
    feed(16'h0001); w = lfsr_next(w);
    chk("corrupt_pulse", err_pulse_a, 1);
    chk("corrupt_count", err_count_a, 1);
    chk("corrupt_locked", locked_a, 1);
    feed(w); w = lfsr_next(w);
    chk("resume_pulse", err_pulse_a, 0);
    chk("resume_count", err_count_a, 1);
    chk("resume_locked", locked_a, 1);
    feed(w); w = lfsr_next(w);
    chk("resume2_count", err_count_a, 1);

    // Clear, then three consecutive wrong words drop lock.
    idle(1'b1);
    chk("clr_count", err_count_a, 0);
    chk("clr_locked", locked_a, 1);
    feed(~w); w = lfsr_next(w);
    chk("miss1_count", err_count_a, 1);
    feed(~w); w = lfsr_next(w);
    chk("miss2_count", err_count_a, 2);
    chk("miss2_locked", locked_a, 1);
    feed(~w); w = lfsr_next(w);
    chk("miss3_count", err_count_a, 3);
    chk("miss3_pulse", err_pulse_a, 1);
    chk("miss3_locked", locked_a, 0);
    for (int i = 0; i < 4; i++) begin
      feed(w); w = lfsr_next(w);
    end
    chk("relock_after4", locked_a, 0);
    feed(w); w = lfsr_next(w);
    chk("relock_after5", locked_a, 1);
    chk("relock_count", err_count_a, 3);

    // Zero words never seed.
    do_reset();
    for (int i = 0; i < 4; i++) feed(16'h0000);
    chk("zero_locked", locked_a, 0);
    chk("zero_count", err_count_a, 0);
    feed(16'h8000); feed(16'h0001); feed(16'h0002); feed(16'h0004);
    chk("walk_after4", locked_a, 0);
    feed(16'h0008);
    chk("walk_locked", locked_a, 1);
    chk("walk_locked_b", locked_b, 1);

    // Saturation on the 2-bit counter.
    w = 16'h0010;
    for (int k = 1; k <= 5; k++) begin
      feed(~w); w = lfsr_next(w);
      chk($sformatf("sat_count_%0d", k), err_count_b, (k < 3) ? k : 3);
      chk($sformatf("sat_pulse_%0d", k), err_pulse_b, 1);
      chk($sformatf("sat_flag_%0d", k), err_sat_b, (k >= 3) ? 1 : 0);
    end
    chk("sat_locked_b", locked_b, 1);
    idle(1'b1);
    chk("satclr_count", err_count_b, 0);
    chk("satclr_flag", err_sat_b, 0);
    chk("satclr_locked", locked_b, 1);
    feed(~w, 1'b1); w = lfsr_next(w);
    chk("clrmiss_count", err_count_b, 1);
    chk("clrmiss_pulse", err_pulse_b, 1);

    // Async reset while locked with two errors.
    do_reset();
    w = 16'hACE1;
    for (int i = 0; i < 5; i++) begin
      feed(w); w = lfsr_next(w);
    end
    feed(~w); w = lfsr_next(w);
    feed(~w); w = lfsr_next(w);
    chk("pre_rst_count", err_count_a, 2);
    chk("pre_rst_pulse", err_pulse_a, 1);
    chk("pre_rst_locked", locked_a, 1);
    nReset = 1'b0;
    #1;
    chk("async_locked", locked_a, 0);
    chk("async_count", err_count_a, 0);
    chk("async_pulse", err_pulse_a, 0);
    #1;
    nReset = 1'b1;
    feed(16'h0000);
    chk("post_rst_locked", locked_a, 0);
    for (int i = 0; i < 4; i++) begin
      feed(w); w = lfsr_next(w);
    end
    chk("post_rst_after4", locked_a, 0);
    feed(w); w = lfsr_next(w);
    chk("post_rst_locked5", locked_a, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
